// File: rtl/pipe_controller.sv
// DE-stage control unit for the 3-stage RV32I+Zicsr pipeline.
// It decodes DE, registers the MW controls, and handles flush, stall and forwarding.
module pipe_controller #(
  parameter int ALUOP_W = 4,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst_de,
  input  logic               valid_de,
  input  logic               br_taken,
  output logic               sel_a,
  output logic               sel_b,
  output logic [ALUOP_W-1:0] aluop,
  output logic [2:0]         br_type,
  output logic               br_take,
  output logic               fwd_a,
  output logic               fwd_b,
  output logic               stall,
  output logic               illegal,
  output logic               rf_en_mw,
  output logic               rd_en_mw,
  output logic               wr_en_mw,
  output logic               csr_wr_mw,
  output logic               csr_rd_mw,
  output logic               is_mret_mw,
  output logic [1:0]         wb_sel_mw,
  output logic [2:0]         mem_acc_mode_mw,
  output logic [4:0]         rd_mw,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2;
  localparam logic [3:0] A_SLT = 4'd3, A_SLTU = 4'd4, A_XOR = 4'd5;
  localparam logic [3:0] A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8;
  localparam logic [3:0] A_AND = 4'd9, A_LUI = 4'd10;

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;

  assign op  = inst_de[6:0];
  assign rd  = inst_de[11:7];
  assign f3  = inst_de[14:12];
  assign rs1 = inst_de[19:15];
  assign rs2 = inst_de[24:20];
  assign f7  = inst_de[31:25];

  function automatic logic [3:0] alu_fn(input logic [2:0] f, input logic alt);
    unique case (f)
      3'b000:  return alt ? A_SUB : A_ADD;
      3'b001:  return A_SLL;
      3'b010:  return A_SLT;
      3'b011:  return A_SLTU;
      3'b100:  return A_XOR;
      3'b101:  return alt ? A_SRA : A_SRL;
      3'b110:  return A_OR;
      default: return A_AND;
    endcase
  endfunction

  logic       is_r, is_i, is_ld, is_st, is_br, is_lui;
  logic       is_aui, is_jal, is_jalr, is_sys;
  logic [3:0] alu_d;
  logic [1:0] wb_d;
  logic [2:0] mode_d;
  logic       rf_d, rde_d, wr_d, cw_d, cr_d, mret_d;
  logic       ill, use1, use2, jump;

  assign is_r    = op == 7'b0110011;
  assign is_i    = op == 7'b0010011;
  assign is_ld   = op == 7'b0000011;
  assign is_st   = op == 7'b0100011;
  assign is_br   = op == 7'b1100011;
  assign is_lui  = op == 7'b0110111;
  assign is_aui  = op == 7'b0010111;
  assign is_jal  = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111;
  assign is_sys  = op == 7'b1110011;

  always_comb begin
    sel_a   = 1'b1;
    sel_b   = 1'b0;
    alu_d   = A_ADD;
    br_type = 3'b111;
    wb_d    = 2'b01;
    mode_d  = 3'b111;
    rf_d    = 1'b0;
    rde_d   = 1'b0;
    wr_d    = 1'b0;
    cw_d    = 1'b0;
    cr_d    = 1'b0;
    mret_d  = 1'b0;
    ill     = 1'b0;
    use1    = 1'b0;
    use2    = 1'b0;
    jump    = 1'b0;
    unique case (1'b1)
      is_r: begin
        alu_d = alu_fn(f3, f7[5]);
        rf_d  = 1'b1;
        use1  = 1'b1;
        use2  = 1'b1;
        ill   = !(f7 == 7'h00 ||
                  (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      is_i: begin
        sel_b = 1'b1;
        alu_d = alu_fn(f3, f3 == 3'b101 && f7[5]);
        rf_d  = 1'b1;
        use1  = 1'b1;
        ill   = (f3 == 3'b001 && f7 != 7'h00) ||
                (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      is_ld: begin
        sel_b = 1'b1;
        rf_d  = 1'b1;
        rde_d = 1'b1;
        wb_d  = 2'b10;
        use1  = 1'b1;
        unique case (f3)
          3'b000:  mode_d = 3'b000;
          3'b001:  mode_d = 3'b001;
          3'b010:  mode_d = 3'b010;
          3'b100:  mode_d = 3'b011;
          3'b101:  mode_d = 3'b100;
          default: ill = 1'b1;
        endcase
      end
      is_st: begin
        sel_b  = 1'b1;
        wr_d   = 1'b1;
        use1   = 1'b1;
        use2   = 1'b1;
        mode_d = f3;
        ill    = f3 > 3'b010;
      end
      is_br: begin
        sel_a   = 1'b0;
        sel_b   = 1'b1;
        br_type = f3;
        use1    = 1'b1;
        use2    = 1'b1;
        ill     = f3 == 3'b010 || f3 == 3'b011;
      end
      is_lui: begin
        sel_b = 1'b1;
        alu_d = A_LUI;
        rf_d  = 1'b1;
      end
      is_aui: begin
        sel_a = 1'b0;
        sel_b = 1'b1;
        rf_d  = 1'b1;
      end
      is_jal: begin
        sel_a = 1'b0;
        sel_b = 1'b1;
        rf_d  = 1'b1;
        wb_d  = 2'b00;
        jump  = 1'b1;
      end
      is_jalr: begin
        sel_b = 1'b1;
        rf_d  = 1'b1;
        wb_d  = 2'b00;
        use1  = 1'b1;
        jump  = 1'b1;
        ill   = f3 != 3'b000;
      end
      is_sys: begin
        if (inst_de == 32'h3020_0073) begin
          mret_d = 1'b1;
          jump   = 1'b1;
        end else if (f3 == 3'b001) begin
          cw_d = 1'b1;
          use1 = 1'b1;
        end else if (f3 == 3'b010) begin
          cr_d = 1'b1;
          rf_d = 1'b1;
          wb_d = 2'b11;
          use1 = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
  end

  logic flush_q, hit1, hit2, prod, kill, bubble;

  assign aluop   = ALUOP_W'(alu_d);
  assign illegal = valid_de & ill;

  // Source matches on the MW destination; x0 never creates a dependency.
  assign hit1 = use1 & ~ill & (rd_mw != 5'd0) & (rd_mw == rs1);
  assign hit2 = use2 & ~ill & (rd_mw != 5'd0) & (rd_mw == rs2);
  assign prod = (FWD_EN != 0) ? rd_en_mw : rf_en_mw;
  assign stall = ~flush_q & valid_de & prod & (hit1 | hit2);

  assign fwd_a = (FWD_EN != 0) & rf_en_mw & ~rd_en_mw & hit1;
  assign fwd_b = (FWD_EN != 0) & rf_en_mw & ~rd_en_mw & hit2;

  assign kill    = flush_q | stall | ~valid_de;
  assign bubble  = kill | ill;
  assign br_take = ~bubble & (jump | (is_br & br_taken));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_en_mw        <= 1'b0;
      rd_en_mw        <= 1'b0;
      wr_en_mw        <= 1'b0;
      csr_wr_mw       <= 1'b0;
      csr_rd_mw       <= 1'b0;
      is_mret_mw      <= 1'b0;
      wb_sel_mw       <= 2'b01;
      mem_acc_mode_mw <= 3'b111;
      rd_mw           <= 5'd0;
      flush_q         <= 1'b0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
    end else begin
      rf_en_mw        <= rf_d & ~bubble;
      rd_en_mw        <= rde_d & ~bubble;
      wr_en_mw        <= wr_d & ~bubble;
      csr_wr_mw       <= cw_d & ~bubble;
      csr_rd_mw       <= cr_d & ~bubble;
      is_mret_mw      <= mret_d & ~bubble;
      wb_sel_mw       <= bubble ? 2'b01 : wb_d;
      mem_acc_mode_mw <= bubble ? 3'b111 : mode_d;
      rd_mw           <= (rf_d & ~bubble) ? rd : 5'd0;
      flush_q         <= br_take;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_q && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller; counters narrowed to 3 bits
// so saturation is reachable in a short run.
module tb_pipe_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_de;
  logic        valid_de, br_taken;
  logic        sel_a, sel_b, br_take, fwd_a, fwd_b, stall, illegal;
  logic [3:0]  aluop;
  logic [2:0]  br_type;
  logic        rf_en_mw, rd_en_mw, wr_en_mw, csr_wr_mw, csr_rd_mw, is_mret_mw;
  logic [1:0]  wb_sel_mw;
  logic [2:0]  mem_acc_mode_mw;
  logic [4:0]  rd_mw;
  logic [2:0]  stall_cnt, flush_cnt;

  int npass = 0;
  int nchk  = 0;

  pipe_controller #(.ALUOP_W(4), .FWD_EN(1), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .inst_de(inst_de), .valid_de(valid_de),
    .br_taken(br_taken), .sel_a(sel_a), .sel_b(sel_b), .aluop(aluop),
    .br_type(br_type), .br_take(br_take), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .illegal(illegal), .rf_en_mw(rf_en_mw),
    .rd_en_mw(rd_en_mw), .wr_en_mw(wr_en_mw), .csr_wr_mw(csr_wr_mw),
    .csr_rd_mw(csr_rd_mw), .is_mret_mw(is_mret_mw), .wb_sel_mw(wb_sel_mw),
    .mem_acc_mode_mw(mem_acc_mode_mw), .rd_mw(rd_mw),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADD3  = 32'h0020_81B3;
  localparam logic [31:0] SUB3  = 32'h4020_81B3;
  localparam logic [31:0] BADR  = 32'h4020_91B3;
  localparam logic [31:0] LW5   = 32'h0000_A283;
  localparam logic [31:0] ADD6  = 32'h0022_8333;
  localparam logic [31:0] ADDI7 = 32'h0050_0393;
  localparam logic [31:0] ADD8  = 32'h0073_8433;
  localparam logic [31:0] ADDI0 = 32'h0050_0013;
  localparam logic [31:0] ADD80 = 32'h0000_0433;
  localparam logic [31:0] BEQ5  = 32'h0022_8463;
  localparam logic [31:0] BEQ1  = 32'h0020_8463;
  localparam logic [31:0] SW    = 32'h0020_A023;
  localparam logic [31:0] JAL1  = 32'h0000_00EF;
  localparam logic [31:0] CSRW  = 32'h3000_9073;
  localparam logic [31:0] MRET  = 32'h3020_0073;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_de = 1'b0; inst_de = NOP; br_taken = 1'b0;
    #3;
    chk("rst_rf", 32'(rf_en_mw), 0);
    chk("rst_mode", 32'(mem_acc_mode_mw), 7);
    chk("rst_wb", 32'(wb_sel_mw), 1);
    chk("rst_fcnt", 32'(flush_cnt), 0);
    chk("rst_scnt", 32'(stall_cnt), 0);
    #9 rst = 1'b0;
    tick();

    // ALU decode
    valid_de = 1'b1; inst_de = ADD3; #1;
    chk("add_op", 32'(aluop), 0);
    chk("add_ill", 32'(illegal), 0);
    tick();
    chk("add_rf", 32'(rf_en_mw), 1);
    chk("add_rd", 32'(rd_mw), 3);
    inst_de = SUB3; #1;
    chk("sub_op", 32'(aluop), 1);
    tick();
    chk("sub_rf", 32'(rf_en_mw), 1);
    inst_de = BADR; #1;
    chk("bad_ill", 32'(illegal), 1);
    tick();
    chk("bad_rf", 32'(rf_en_mw), 0);
    chk("bad_mode", 32'(mem_acc_mode_mw), 7);

    // load-use
    inst_de = LW5; #1;
    chk("lw_stall", 32'(stall), 0);
    tick();
    chk("lw_rden", 32'(rd_en_mw), 1);
    chk("lw_rd", 32'(rd_mw), 5);
    chk("lw_wb", 32'(wb_sel_mw), 2);
    chk("lw_mode", 32'(mem_acc_mode_mw), 2);
    inst_de = ADD6; #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_fwda", 32'(fwd_a), 0);
    tick();
    chk("lu_bub", 32'(rf_en_mw), 0);
    chk("lu_scnt", 32'(stall_cnt), 1);
    chk("lu_stall2", 32'(stall), 0);
    chk("lu_fwda2", 32'(fwd_a), 0);
    tick();
    chk("lu_rd6", 32'(rd_mw), 6);

    // forwarding
    inst_de = ADDI7;
    tick();
    inst_de = ADD8; #1;
    chk("fw_a", 32'(fwd_a), 1);
    chk("fw_b", 32'(fwd_b), 1);
    chk("fw_stall", 32'(stall), 0);
    tick();
    inst_de = ADDI0;
    tick();
    inst_de = ADD80; #1;
    chk("fw0_a", 32'(fwd_a), 0);
    chk("fw0_b", 32'(fwd_b), 0);

    // taken branch behind a load: stall first, then redirect
    inst_de = LW5;
    tick();
    inst_de = BEQ5; br_taken = 1'b1; #1;
    chk("sb_stall", 32'(stall), 1);
    chk("sb_take", 32'(br_take), 0);
    tick();
    chk("sb_scnt", 32'(stall_cnt), 2);
    chk("sb_stall2", 32'(stall), 0);
    chk("sb_take2", 32'(br_take), 1);
    tick();
    chk("sb_kill", 32'(br_take), 0);
    br_taken = 1'b0; inst_de = NOP;
    tick();
    chk("sb_fcnt", 32'(flush_cnt), 1);

    // branch flush kills the following store
    inst_de = BEQ1; #1;
    chk("bnt_take", 32'(br_take), 0);
    br_taken = 1'b1; #1;
    chk("beq_take", 32'(br_take), 1);
    chk("beq_type", 32'(br_type), 0);
    tick();
    inst_de = SW; br_taken = 1'b0; #1;
    chk("sw_take", 32'(br_take), 0);
    tick();
    chk("sw_kill", 32'(wr_en_mw), 0);
    chk("sw_fcnt", 32'(flush_cnt), 2);
    tick();
    chk("sw_wr", 32'(wr_en_mw), 1);
    chk("sw_mode", 32'(mem_acc_mode_mw), 2);

    // asynchronous reset mid-cycle
    #3 rst = 1'b1; #1;
    chk("ar_wr", 32'(wr_en_mw), 0);
    chk("ar_mode", 32'(mem_acc_mode_mw), 7);
    chk("ar_wb", 32'(wb_sel_mw), 1);
    chk("ar_scnt", 32'(stall_cnt), 0);
    chk("ar_fcnt", 32'(flush_cnt), 0);
    #2 rst = 1'b0;
    tick();

    // JAL, CSR, MRET
    inst_de = JAL1; #1;
    chk("jal_take", 32'(br_take), 1);
    tick();
    chk("jal_wb", 32'(wb_sel_mw), 0);
    chk("jal_rd", 32'(rd_mw), 1);
    inst_de = CSRW; #1;
    chk("csr_take", 32'(br_take), 0);
    tick();
    chk("csr_kill", 32'(csr_wr_mw), 0);
    chk("jal_fcnt", 32'(flush_cnt), 1);
    tick();
    chk("csr_wr", 32'(csr_wr_mw), 1);
    inst_de = MRET; #1;
    chk("mret_take", 32'(br_take), 1);
    tick();
    chk("mret_mw", 32'(is_mret_mw), 1);

    // saturation
    inst_de = JAL1;
    repeat (20) tick();
    chk("sat_fcnt", 32'(flush_cnt), 7);
    repeat (4) tick();
    chk("sat_hold", 32'(flush_cnt), 7);
    chk("sat_scnt", 32'(stall_cnt), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Registered, hazard-aware control unit for the 3-stage (IF / DE / MW) RV32I+Zicsr pipeline. Decodes the DE-stage instruction into datapath controls, carries memory/writeback/CSR controls into the MW stage through a pipeline register, and resolves control hazards. The hazards handled are branch/jump flush, load-use stall with bubble injection and operand-forwarding selects. It also flags illegal encodings and keeps saturating stall/flush event counters.

## Interface
- ALUOP_W, 4: aluop width
- FWD_EN, 1: 1 = generate forwarding selects; 0 = fwd_a/fwd_b tied 0 and every RAW on an MW producer stalls
- CNT_W, 16: width of perf counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- inst_de  in  32  instruction in DE
- valid_de  in  1  DE holds a real instruction
- br_taken  in  1  comparison result from branch-condition block (DE)
- sel_a, sel_b  out  1  DE ALU operand muxes (1 = rs1 / imm)
- aluop  out  ALUOP_W  DE ALU operation
- br_type  out  3  funct3 for branch instructions, else 3'b111
- br_take  out  1  redirect PC this cycle
- fwd_a, fwd_b  out  1  select MW ALU result for rs1 / rs2
- stall  out  1  freeze PC and IF/DE register
- illegal  out  1  DE instruction undecodable
- rf_en_mw, rd_en_mw, wr_en_mw, csr_wr_mw, csr_rd_mw, is_mret_mw  out  1 each  registered MW controls
- wb_sel_mw  out  2  00 = PC+4, 01 = ALU, 10 = memory, 11 = CSR
- mem_acc_mode_mw  out  3  000 = B, 001 = H, 010 = W, 011 = BU, 100 = HU, 111 = none
- rd_mw  out  5  destination register in MW
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation

ALU operation codes:
- ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, LUI-pass A.
- Loads, stores, branches, AUIPC, JAL and JALR all use ADD.

Decode per opcode:
- R-type, I-ALU: funct7 other than 0000000 or 0100000 (where funct7 is meaningful) is illegal.
- Load: funct3 011, 110 and 111 are illegal.
- Store: funct3 greater than 010 is illegal.
- Branch: funct3 010 and 011 are illegal.
- SYSTEM: 0x30200073 → is_mret. funct3 001 → csr_wr. funct3 010 → csr_rd, wb_sel = 11. Any other SYSTEM encoding is illegal.
- All decode outputs have full defaults; no latches.
- An illegal or invalid instruction, or a killed one, becomes a bubble: all MW enables 0, mem_acc_mode 111, br_take 0.

Kill condition:
- kill = flush_q | stall | ~valid_de.

br_take (combinational) = ~kill & (JAL | JALR | MRET | (branch & br_taken)).

flush_q register:
- Set for exactly one cycle after br_take = 1.
- The wrong-path instruction arriving in DE is killed while flush_q is high; flush_cnt increments.

Load-use hazard (stall):
- Condition: rd_en_mw & rd_mw ≠ 0 & rd_mw matches a source register the DE instruction actually reads.
- Result: stall = 1 and a bubble is injected into MW.
- Duration: one cycle, because the next cycle MW holds the bubble. stall_cnt increments.
- With FWD_EN = 0, any rf_en_mw RAW stalls.

Forwarding:
- fwd_a = FWD_EN & rf_en_mw & ~rd_en_mw & rd_mw ≠ 0 & rd_mw == rs1 (rs1 used).
- fwd_b: the same, for rs2.

Precedence: rst > flush_q > stall. During flush_q, no stall is raised for the killed instruction.

Counters saturate at all-ones and never wrap.

## Timing
- DE outputs (sel_a, sel_b, aluop, br_type, br_take, fwd_a/fwd_b, stall, illegal) are combinational from inst_de, br_taken and MW registers.
- MW outputs update on posedge clk; decode-to-MW latency is 1 cycle.
- Reset, asynchronous on rst high:
  - all *_mw enables 0, wb_sel_mw 01, mem_acc_mode_mw 111, rd_mw 0;
  - flush_q 0;
  - counters 0.
- Reset asserted mid-stall or mid-flush clears the state immediately. The first cycle after release behaves as a fresh pipeline.
- A taken branch in DE while MW holds a load with a matching rd: stall wins; br_take is held off until the stall cycle ends.

## Test plan
- Reset: rst = 1 asynchronously mid-cycle → rf_en_mw = 0, mem_acc_mode_mw = 111, wb_sel_mw = 01, counters 0, before the next clock edge.
- ALU decode: add x3,x1,x2 (0x002081B3), then sub (0x402081B3) → aluop 0 then 1, rf_en_mw = 1 and rd_mw = 3 one cycle later. funct7 = 0x20 with funct3 = 001 → illegal = 1 and MW bubble.
- Load-use: lw x5,0(x1), then add x6,x5,x2 → stall = 1 for exactly one cycle, MW bubble, stall_cnt = 1. Then add proceeds with fwd_a = 0.
- Forwarding: addi x7,x0,5, then add x8,x7,x7 → fwd_a = fwd_b = 1, no stall. Same pair with rd = x0 → no forwarding.
- Flush: beq taken (br_taken = 1) → br_take = 1. Next DE instruction (sw) is killed: wr_en_mw = 0, flush_cnt = 1. JAL → br_take = 1, wb_sel_mw = 00.
- CSR/MRET: csrrw (funct3 001) → csr_wr_mw = 1. 0x30200073 → is_mret_mw = 1, br_take = 1. flush_cnt forced to 2^CNT_W−1 stays saturated on further flushes.
